// File: rtl/avalon_rw_arbiter.sv
// Weighted round-robin arbiter sharing one Avalon-MM master between a read and a write requester.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module avalon_rw_arbiter #(
   parameter int BUSWIDTH        = 512,
   parameter int BYTEENABLEWIDTH = 64,
   parameter int MAX_STREAK      = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [63:0]                RdMstAddr_i,
   input  logic                       RdMstRead_i,
   input  logic [BYTEENABLEWIDTH-1:0] RdMstByteEnable_i,
   input  logic                       RdMstLock_i,
   output logic [BUSWIDTH-1:0]        RdMstReadData_o,
   output logic                       RdMstWaitReq_o,
   input  logic [63:0]                WrMstAddr_i,
   input  logic                       WrMstWrite_i,
   input  logic [BYTEENABLEWIDTH-1:0] WrMstByteEnable_i,
   input  logic [BUSWIDTH-1:0]        WrMstWriteData_i,
   input  logic                       WrMstLock_i,
   output logic                       WrMstWaitReq_o,
   output logic [63:0]                AvalonAddr_o,
   output logic                       AvalonRead_o,
   output logic                       AvalonWrite_o,
   output logic [BYTEENABLEWIDTH-1:0] AvalonByteEnable_o,
   output logic [BUSWIDTH-1:0]        AvalonWriteData_o,
   output logic                       AvalonLock_o,
   input  logic [BUSWIDTH-1:0]        AvalonReadData_i,
   input  logic                       AvalonWaitReq_i,
   input  logic                       PerfClr_i,
   output logic [31:0]                PerfRdGnt_o,
   output logic [31:0]                PerfWrGnt_o,
   output logic [31:0]                PerfRdStall_o
);

   localparam logic       LP_RD = 1'b0;
   localparam logic       LP_WR = 1'b1;
   localparam logic [7:0] LP_MAX_STREAK = 8'(MAX_STREAK);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RD_OWN = 2'd1,
      S_WR_OWN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_gnt;
   logic [7:0]  r_streak;

   logic        w_pick_wr;
   logic        w_gnt_rd;
   logic        w_gnt_wr;
   logic        w_drv_rd;
   logic        w_drv_wr;
   logic        w_acc_rd;
   logic        w_acc_wr;
   logic        w_acc;
   logic        w_lock;
   logic        w_rd_waitreq;
   logic        w_wr_waitreq;

   // Contended pick: repeat the last winner until its streak is used up.
   // A zero streak (only after reset) rotates, so read wins the first tie.
   always_comb begin
      w_pick_wr = 1'b0;
      if (WrMstWrite_i && !RdMstRead_i) begin
         w_pick_wr = 1'b1;
      end else if (WrMstWrite_i && RdMstRead_i) begin
         if (r_streak != 8'd0 && r_streak < LP_MAX_STREAK)
            w_pick_wr = r_last_gnt;
         else
            w_pick_wr = ~r_last_gnt;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rstn)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_gnt_rd) begin
               if (!(w_acc_rd && !RdMstLock_i))
                  w_next_state = S_RD_OWN;
            end else if (w_gnt_wr) begin
               if (!(w_acc_wr && !WrMstLock_i))
                  w_next_state = S_WR_OWN;
            end
         end
         S_RD_OWN: begin
            if ((w_acc_rd || !RdMstRead_i) && !RdMstLock_i)
               w_next_state = S_IDLE;
         end
         S_WR_OWN: begin
            if ((w_acc_wr || !WrMstWrite_i) && !WrMstLock_i)
               w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Grant decode; everything is held off while reset is asserted
   always_comb begin
      w_gnt_rd = 1'b0;
      w_gnt_wr = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_gnt_wr = (RdMstRead_i || WrMstWrite_i) && w_pick_wr;
            w_gnt_rd = (RdMstRead_i || WrMstWrite_i) && !w_pick_wr;
         end
         S_RD_OWN: w_gnt_rd = 1'b1;
         S_WR_OWN: w_gnt_wr = 1'b1;
         default: begin
            w_gnt_rd = 1'b0;
            w_gnt_wr = 1'b0;
         end
      endcase
      if (!rstn) begin
         w_gnt_rd = 1'b0;
         w_gnt_wr = 1'b0;
      end
   end

   assign w_drv_rd     = w_gnt_rd && RdMstRead_i;
   assign w_drv_wr     = w_gnt_wr && WrMstWrite_i;
   assign w_acc_rd     = w_drv_rd && !AvalonWaitReq_i;
   assign w_acc_wr     = w_drv_wr && !AvalonWaitReq_i;
   assign w_acc        = w_acc_rd || w_acc_wr;
   assign w_lock       = (w_gnt_rd && RdMstLock_i) || (w_gnt_wr && WrMstLock_i);
   assign w_rd_waitreq = w_gnt_rd ? AvalonWaitReq_i : 1'b1;
   assign w_wr_waitreq = w_gnt_wr ? AvalonWaitReq_i : 1'b1;

   assign AvalonRead_o       = w_drv_rd;
   assign AvalonWrite_o      = w_drv_wr;
   assign AvalonLock_o       = w_lock;
   assign AvalonAddr_o       = w_gnt_wr ? WrMstAddr_i : RdMstAddr_i;
   assign AvalonByteEnable_o = w_gnt_wr ? WrMstByteEnable_i : RdMstByteEnable_i;
   assign AvalonWriteData_o  = WrMstWriteData_i;
   assign RdMstReadData_o    = AvalonReadData_i;
   assign RdMstWaitReq_o     = w_rd_waitreq;
   assign WrMstWaitReq_o     = w_wr_waitreq;

   // Fairness history, advanced on every accepted command
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_last_gnt <= LP_WR;
         r_streak   <= 8'd0;
      end else if (w_acc) begin
         if ((w_acc_wr ? LP_WR : LP_RD) == r_last_gnt) begin
            if (r_streak != 8'hFF)
               r_streak <= r_streak + 8'd1;
         end else begin
            r_last_gnt <= w_acc_wr ? LP_WR : LP_RD;
            r_streak   <= 8'd1;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_perf_rd_gnt;
   logic [31:0] r_perf_wr_gnt;
   logic [31:0] r_perf_rd_stall;

   always_ff @(posedge clk) begin
      if (!rstn || PerfClr_i) begin
         r_perf_rd_gnt   <= 32'd0;
         r_perf_wr_gnt   <= 32'd0;
         r_perf_rd_stall <= 32'd0;
      end else begin
         if (w_acc_rd)
            r_perf_rd_gnt <= r_perf_rd_gnt + 32'd1;
         if (w_acc_wr)
            r_perf_wr_gnt <= r_perf_wr_gnt + 32'd1;
         if (RdMstRead_i && w_rd_waitreq)
            r_perf_rd_stall <= r_perf_rd_stall + 32'd1;
      end
   end

   assign PerfRdGnt_o   = r_perf_rd_gnt;
   assign PerfWrGnt_o   = r_perf_wr_gnt;
   assign PerfRdStall_o = r_perf_rd_stall;
`else
   logic w_unused_perfclr;

   assign w_unused_perfclr = PerfClr_i;
   assign PerfRdGnt_o      = 32'd0;
   assign PerfWrGnt_o      = 32'd0;
   assign PerfRdStall_o    = 32'd0;
`endif

endmodule

// File: tb/tb_avalon_rw_arbiter.sv
// Directed self-checking bench for avalon_rw_arbiter.
// Counter expectations follow ARB_PERF_CNT_EN.
module tb_avalon_rw_arbiter;

   localparam int BW  = 512;
   localparam int BEW = 64;

`ifdef ARB_PERF_CNT_EN
   localparam logic [31:0] EXP_RG = 32'd7;
   localparam logic [31:0] EXP_WG = 32'd5;
   localparam logic [31:0] EXP_RS = 32'd9;
`else
   localparam logic [31:0] EXP_RG = 32'd0;
   localparam logic [31:0] EXP_WG = 32'd0;
   localparam logic [31:0] EXP_RS = 32'd0;
`endif

   logic            clk;
   logic            rstn;
   logic [63:0]     rd_addr;
   logic            rd_read;
   logic [BEW-1:0]  rd_be;
   logic            rd_lock;
   logic [BW-1:0]   rd_data;
   logic            rd_wait;
   logic [63:0]     wr_addr;
   logic            wr_write;
   logic [BEW-1:0]  wr_be;
   logic [BW-1:0]   wr_data;
   logic            wr_lock;
   logic            wr_wait;
   logic [63:0]     av_addr;
   logic            av_read;
   logic            av_write;
   logic [BEW-1:0]  av_be;
   logic [BW-1:0]   av_wdata;
   logic            av_lock;
   logic [BW-1:0]   av_rdata;
   logic            av_wait;
   logic            perf_clr;
   logic [31:0]     perf_rg;
   logic [31:0]     perf_wg;
   logic [31:0]     perf_rs;

   int n_asrt;
   int n_fail;
   int n_wacc;
   logic exp_rd;

   avalon_rw_arbiter #(
      .BUSWIDTH(BW),
      .BYTEENABLEWIDTH(BEW),
      .MAX_STREAK(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .RdMstAddr_i(rd_addr),
      .RdMstRead_i(rd_read),
      .RdMstByteEnable_i(rd_be),
      .RdMstLock_i(rd_lock),
      .RdMstReadData_o(rd_data),
      .RdMstWaitReq_o(rd_wait),
      .WrMstAddr_i(wr_addr),
      .WrMstWrite_i(wr_write),
      .WrMstByteEnable_i(wr_be),
      .WrMstWriteData_i(wr_data),
      .WrMstLock_i(wr_lock),
      .WrMstWaitReq_o(wr_wait),
      .AvalonAddr_o(av_addr),
      .AvalonRead_o(av_read),
      .AvalonWrite_o(av_write),
      .AvalonByteEnable_o(av_be),
      .AvalonWriteData_o(av_wdata),
      .AvalonLock_o(av_lock),
      .AvalonReadData_i(av_rdata),
      .AvalonWaitReq_i(av_wait),
      .PerfClr_i(perf_clr),
      .PerfRdGnt_o(perf_rg),
      .PerfWrGnt_o(perf_wg),
      .PerfRdStall_o(perf_rs)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_perf(input string tag, input logic [31:0] rg,
                           input logic [31:0] wg, input logic [31:0] rs);
      chk({tag, "_rg"}, 512'(perf_rg), 512'(rg));
      chk({tag, "_wg"}, 512'(perf_wg), 512'(wg));
      chk({tag, "_rs"}, 512'(perf_rs), 512'(rs));
   endtask

   initial begin
      n_asrt   = 0;
      n_fail   = 0;
      n_wacc   = 0;
      rstn     = 1'b0;
      rd_addr  = 64'h1000_0000_0000_00A0;
      wr_addr  = 64'h2000_0000_0000_00B0;
      rd_be    = 64'h0000_0000_FFFF_FFFF;
      wr_be    = 64'hFFFF_0000_0000_FFFF;
      wr_data  = {16{32'hDEAD_BEEF}};
      av_rdata = {16{32'h1234_5678}};
      rd_read  = 1'b1;
      wr_write = 1'b1;
      rd_lock  = 1'b0;
      wr_lock  = 1'b0;
      av_wait  = 1'b0;
      perf_clr = 1'b0;

      // Reset forces the command off and stalls both sides
      #1;
      chk("rst_read", 512'(av_read), 512'(1'b0));
      chk("rst_write", 512'(av_write), 512'(1'b0));
      chk("rst_rdwait", 512'(rd_wait), 512'(1'b1));
      chk("rst_wrwait", 512'(wr_wait), 512'(1'b1));
      tick;
      tick;
      chk_perf("rst_perf", 32'd0, 32'd0, 32'd0);
      rstn = 1'b1;

      // Both requesting: first tie goes to read, then 4/4 alternation
      for (int i = 0; i < 12; i++) begin
         #1;
         exp_rd = ((i / 4) % 2) == 0;
         chk($sformatf("rr_read%0d", i), 512'(av_read), 512'(exp_rd));
         chk($sformatf("rr_write%0d", i), 512'(av_write), 512'(!exp_rd));
         chk($sformatf("rr_addr%0d", i), 512'(av_addr),
             512'(exp_rd ? rd_addr : wr_addr));
         chk($sformatf("rr_rdwait%0d", i), 512'(rd_wait), 512'(!exp_rd));
         tick;
      end

      // Write only, no backpressure
      rd_read = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("wo_write%0d", i), 512'(av_write), 512'(1'b1));
         chk($sformatf("wo_wrwait%0d", i), 512'(wr_wait), 512'(1'b0));
         chk($sformatf("wo_rdwait%0d", i), 512'(rd_wait), 512'(1'b1));
         chk($sformatf("wo_be%0d", i), 512'(av_be), 512'(wr_be));
         chk($sformatf("wo_data%0d", i), av_wdata, wr_data);
         if (av_write && !wr_wait)
            n_wacc++;
         tick;
      end
      chk("wo_accepts", 512'(n_wacc), 512'(10));

      // Stalled read holds the bus while a write rises
      wr_write = 1'b0;
      rd_read  = 1'b1;
      av_wait  = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         if (c == 2)
            wr_write = 1'b1;
         if (c == 4)
            av_wait = 1'b0;
         #1;
         chk($sformatf("st_read%0d", c), 512'(av_read), 512'(1'b1));
         chk($sformatf("st_addr%0d", c), 512'(av_addr), 512'(rd_addr));
         chk($sformatf("st_write%0d", c), 512'(av_write), 512'(1'b0));
         chk($sformatf("st_wrwait%0d", c), 512'(wr_wait), 512'(1'b1));
         chk($sformatf("st_rdwait%0d", c), 512'(rd_wait), 512'(c < 4));
         tick;
      end
      chk("st_rdata", rd_data, av_rdata);
      rd_read = 1'b0;
      #1;
      chk("st5_write", 512'(av_write), 512'(1'b1));
      chk("st5_read", 512'(av_read), 512'(1'b0));
      chk("st5_addr", 512'(av_addr), 512'(wr_addr));
      chk("st5_wrwait", 512'(wr_wait), 512'(1'b0));
      tick;

      // Locked writes keep the pending read out
      rd_read  = 1'b1;
      wr_write = 1'b1;
      wr_lock  = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         #1;
         chk($sformatf("lk_write%0d", c), 512'(av_write), 512'(1'b1));
         chk($sformatf("lk_read%0d", c), 512'(av_read), 512'(1'b0));
         chk($sformatf("lk_rdwait%0d", c), 512'(rd_wait), 512'(1'b1));
         chk($sformatf("lk_lock%0d", c), 512'(av_lock), 512'(1'b1));
         tick;
      end
      wr_write = 1'b0;
      #1;
      chk("lk4_read", 512'(av_read), 512'(1'b0));
      chk("lk4_write", 512'(av_write), 512'(1'b0));
      chk("lk4_lock", 512'(av_lock), 512'(1'b1));
      chk("lk4_rdwait", 512'(rd_wait), 512'(1'b1));
      tick;
      wr_lock = 1'b0;
      #1;
      chk("lk5_read", 512'(av_read), 512'(1'b0));
      chk("lk5_lock", 512'(av_lock), 512'(1'b0));
      chk("lk5_rdwait", 512'(rd_wait), 512'(1'b1));
      tick;
      #1;
      chk("lk6_read", 512'(av_read), 512'(1'b1));
      chk("lk6_rdwait", 512'(rd_wait), 512'(1'b0));
      chk("lk6_addr", 512'(av_addr), 512'(rd_addr));
      tick;
      rd_read = 1'b0;

      // Nothing requested
      #1;
      chk("id_read", 512'(av_read), 512'(1'b0));
      chk("id_write", 512'(av_write), 512'(1'b0));
      chk("id_lock", 512'(av_lock), 512'(1'b0));
      chk("id_addr", 512'(av_addr), 512'(rd_addr));
      chk("id_be", 512'(av_be), 512'(rd_be));
      chk("id_wdata", av_wdata, wr_data);
      chk("id_rdwait", 512'(rd_wait), 512'(1'b1));
      chk("id_wrwait", 512'(wr_wait), 512'(1'b1));
      tick;

      // Reset during a stalled write
      wr_write = 1'b1;
      av_wait  = 1'b1;
      #1;
      chk("rs_write0", 512'(av_write), 512'(1'b1));
      chk("rs_wrwait0", 512'(wr_wait), 512'(1'b1));
      tick;
      #1;
      chk("rs_write1", 512'(av_write), 512'(1'b1));
      rstn = 1'b0;
      #1;
      chk("rs_write_f", 512'(av_write), 512'(1'b0));
      chk("rs_rdwait_f", 512'(rd_wait), 512'(1'b1));
      chk("rs_wrwait_f", 512'(wr_wait), 512'(1'b1));
      tick;
      rstn    = 1'b1;
      rd_read = 1'b1;
      av_wait = 1'b0;
      #1;
      chk("rs_idle_read", 512'(av_read), 512'(1'b1));
      chk("rs_idle_write", 512'(av_write), 512'(1'b0));
      chk_perf("rs_perf", 32'd0, 32'd0, 32'd0);
      tick;
      rd_read  = 1'b0;
      wr_write = 1'b0;

      // Performance counters
      perf_clr = 1'b1;
      tick;
      perf_clr = 1'b0;
      #1;
      chk_perf("pc_clr0", 32'd0, 32'd0, 32'd0);
      rd_read = 1'b1;
      repeat (7) tick;
      rd_read  = 1'b0;
      wr_write = 1'b1;
      repeat (5) tick;
      wr_write = 1'b0;
      rd_read  = 1'b1;
      av_wait  = 1'b1;
      repeat (9) tick;
      rd_read = 1'b0;
      av_wait = 1'b0;
      tick;
      #1;
      chk_perf("pc_cnt", EXP_RG, EXP_WG, EXP_RS);
      perf_clr = 1'b1;
      rd_read  = 1'b1;
      tick;
      perf_clr = 1'b0;
      rd_read  = 1'b0;
      #1;
      chk_perf("pc_clr1", 32'd0, 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
